rms_chan_scheduler: RTL and testbench

Time-multiplexes one shared mean-square (MS) window accumulator across NCH motor sensor channels, e.g. three phase currents and one vibration channel. It picks channels round-robin, pulls exactly WIN samples from the selected channel and produces one mean-square result per window on a valid/ready output. It sits between the per-channel ADC sample streams and the fault classifier.

---
 rtl/rms_chan_scheduler_if.sv | 43 ++++
 rtl/rms_chan_scheduler.sv | 159 +++++++++++++++
 tb/tb_rms_chan_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rms_chan_scheduler_if.sv
// Bundle of per-channel sample streams, control and the result stream for rms_chan_scheduler.
// master = sample source / result consumer side, slave = the scheduler.
// Optional MS_THRESH_EN adds thresh, m_fault and fault_sticky.
interface rms_chan_scheduler_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  localparam int CW = $clog2(NCH);

  logic              enable;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    s_valid;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_ready;
  logic              m_valid;
  logic              m_ready;
  logic [CW-1:0]     m_ch;
  logic [31:0]       m_ms;
  logic              busy;
`ifdef MS_THRESH_EN
  logic [31:0]       thresh;
  logic              m_fault;
  logic [NCH-1:0]    fault_sticky;
`endif

  modport master (
    output enable, ch_en, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_ms, busy
`ifdef MS_THRESH_EN
    , output thresh
    , input  m_fault, fault_sticky
`endif
  );

  modport slave (
    input  enable, ch_en, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_ms, busy
`ifdef MS_THRESH_EN
    , input  thresh
    , output m_fault, fault_sticky
`endif
  );
endinterface

// File: rtl/rms_chan_scheduler.sv
// Round-robin scheduler sharing one mean-square window accumulator across NCH sample streams.
// Latency: result valid the cycle after the WIN-th accepted sample; 2 cycles DONE->IDLE->ACCUM turnaround.
// Backpressure: s_ready only on the selected channel during ACCUM; result held in DONE until m_ready.
// Optional feature macro: MS_THRESH_EN (threshold compare flag plus sticky per-channel fault bits).
module rms_chan_scheduler #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int LOG2WIN = 10
) (
  input  logic clk,
  input  logic rst,
  rms_chan_scheduler_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int AW = 2*DW + LOG2WIN;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_last;
  logic [CW-1:0]        r_cur;
  logic [CW-1:0]        w_sel;
  logic [CW-1:0]        w_idx;
  logic                 w_sel_found;
  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        w_acc_nxt;
  logic [AW-1:0]        w_shift;
  logic [LOG2WIN-1:0]   r_cnt;
  logic signed [DW-1:0] w_smp;
  logic signed [2*DW-1:0] w_prod;
  logic [31:0]          w_ms;
  logic                 w_accept;
  logic                 w_last_smp;
  logic                 r_m_valid;
  logic [CW-1:0]        r_m_ch;
  logic [31:0]          r_m_ms;
`ifdef MS_THRESH_EN
  logic                 r_m_fault;
  logic [NCH-1:0]       r_fault_sticky;
`endif

  // Pick the first enabled channel above the last served one, wrapping around.
  always_comb begin
    w_sel       = r_last;
    w_sel_found = 1'b0;
    w_idx       = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = CW'((int'(r_last) + i) % NCH);
      if (!w_sel_found && bus.ch_en[w_idx]) begin
        w_sel       = w_idx;
        w_sel_found = 1'b1;
      end
    end
  end

  // Square of the current channel's sample; squares are non-negative so the product is used unsigned.
  assign w_smp      = bus.s_data[r_cur*DW +: DW];
  assign w_prod     = w_smp * w_smp;
  assign w_acc_nxt  = r_acc + {{LOG2WIN{1'b0}}, w_prod};
  assign w_shift    = w_acc_nxt >> LOG2WIN;
  assign w_accept   = (r_state == S_ACCUM) && bus.s_valid[r_cur];
  assign w_last_smp = &r_cnt;

  // Only wide samples can push the mean square past 32 bits; clamp those to all-ones.
  generate
    if (AW > 32) begin : g_sat
      assign w_ms = (|w_shift[AW-1:32]) ? 32'hFFFF_FFFF : w_shift[31:0];
    end else begin : g_nosat
      assign w_ms = 32'(w_shift);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: enable low aborts a window but never a pending result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable && w_sel_found) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (!bus.enable)                  w_state_nxt = S_IDLE;
        else if (w_accept && w_last_smp)  w_state_nxt = S_DONE;
      end
      S_DONE:  if (bus.m_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window datapath, result registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= CW'(NCH-1);
      r_cur     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_ch    <= '0;
      r_m_ms    <= '0;
`ifdef MS_THRESH_EN
      r_m_fault      <= 1'b0;
      r_fault_sticky <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable && w_sel_found) begin
            r_cur <= w_sel;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (bus.enable && w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_smp) begin
              r_m_valid <= 1'b1;
              r_m_ch    <= r_cur;
              r_m_ms    <= w_ms;
`ifdef MS_THRESH_EN
              r_m_fault <= (w_ms > bus.thresh);
`endif
            end
          end
        end
        S_DONE: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_last    <= r_cur;
`ifdef MS_THRESH_EN
            if (r_m_fault) r_fault_sticky[r_m_ch] <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Grant only the selected channel while a window is being collected.
  always_comb begin
    bus.s_ready = '0;
    if (r_state == S_ACCUM) bus.s_ready[r_cur] = 1'b1;
  end

  assign bus.m_valid = r_m_valid;
  assign bus.m_ch    = r_m_ch;
  assign bus.m_ms    = r_m_ms;
  assign bus.busy    = (r_state != S_IDLE);
`ifdef MS_THRESH_EN
  assign bus.m_fault      = r_m_fault;
  assign bus.fault_sticky = r_fault_sticky;
`endif
endmodule

// File: tb/tb_rms_chan_scheduler.sv
// Bench for rms_chan_scheduler: directed table, hand-written corner sequences and a random scoreboard run.
// Main DUT uses WIN=4; a second instance with WIN=1024 covers the full-scale accumulator case.
// Threshold checks are compiled in only when MS_THRESH_EN is defined.
module tb_rms_chan_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rms_chan_scheduler_if #(.NCH(NCH), .DW(DW)) bus ();
  rms_chan_scheduler_if #(.NCH(NCH), .DW(DW)) bus10 ();

  rms_chan_scheduler #(.NCH(NCH), .DW(DW), .LOG2WIN(2))  dut   (.clk(clk), .rst(rst), .bus(bus));
  rms_chan_scheduler #(.NCH(NCH), .DW(DW), .LOG2WIN(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for m_valid", name);
  endtask

  // ---------------- sample source: per-channel streams popped on handshake ----------------
  logic signed [DW-1:0] strm [NCH][256];
  int             ptr [NCH];
  logic [NCH-1:0] hs = '0;
  int             vld_pct = 100;
  bit             src_clr = 1'b0;
  int             viol = 0;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (src_clr)    ptr[c] = 0;
      else if (hs[c]) ptr[c] = ptr[c] + 1;
      bus.s_valid[c] = ($urandom_range(99) < vld_pct);
      bus.s_data[c*DW +: DW] = strm[c][ptr[c] % 256];
    end
    hs = bus.s_valid & bus.s_ready;
    if (((bus.s_ready & ~bus.ch_en) != 0) || !$onehot0(bus.s_ready)) viol++;
  end

  task automatic fill_const(input int c, input int v);
    for (int k = 0; k < 256; k++) strm[c][k] = DW'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    src_clr = 1'b0;
  endtask

  task automatic handshake();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.m_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input int exp_ch, input longint exp_ms);
    bit ok;
    wait_valid(300, ok);
    if (!ok) timeout(tag);
    else begin
      chk({tag, " m_ch"}, longint'(bus.m_ch), exp_ch);
      chk({tag, " m_ms"}, longint'(bus.m_ms), exp_ms);
    end
  endtask

  // Round-robin rule: first enabled channel strictly after last, with wrap.
  function automatic int rr_next(input int last, input logic [NCH-1:0] mask);
    for (int i = 1; i <= NCH; i++)
      if (mask[(last + i) % NCH]) return (last + i) % NCH;
    return -1;
  endfunction

  typedef struct {
    logic [NCH-1:0] ch_en;
    int             exp_ch;
    longint         exp_ms;
  } vec_t;
  vec_t tbl [8];

  initial begin
    bit     ok;
    int     acc_n, last_acc, valid_at, gap, bad, nacc;
    int     model_last;
    int     mptr [NCH];
    logic [NCH-1:0] mask;
    longint sum;

    // Table: constant per-channel streams 100, -7, 5000, -32768 -> ms equals the square.
    tbl[0] = '{4'b1011, 0, 64'd10000};
    tbl[1] = '{4'b1011, 1, 64'd49};
    tbl[2] = '{4'b1011, 3, 64'd1073741824};
    tbl[3] = '{4'b1011, 0, 64'd10000};
    tbl[4] = '{4'b1011, 1, 64'd49};
    tbl[5] = '{4'b0001, 0, 64'd10000};
    tbl[6] = '{4'b0100, 2, 64'd25000000};
    tbl[7] = '{4'b1111, 3, 64'd1073741824};

    rst = 1'b1;
    bus.enable = 1'b0; bus.ch_en = '0; bus.m_ready = 1'b0;
    bus10.enable = 1'b0; bus10.ch_en = '0; bus10.m_ready = 1'b0;
    bus10.s_valid = '0; bus10.s_data = '0;
`ifdef MS_THRESH_EN
    bus.thresh = 32'd0;
    bus10.thresh = 32'hFFFF_FFFF;
`endif
    for (int c = 0; c < NCH; c++) fill_const(c, 0);

    // Full-scale negative samples over a 1024-sample window.
    bus10.s_data = {NCH{16'h8000}};
    bus10.s_valid = 4'b0001;
    bus10.ch_en = 4'b0001;
    bus10.enable = 1'b1;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (bus10.m_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("win1024");
    else begin
      chk("win1024 m_ms", longint'(bus10.m_ms), 64'd1073741824);
      chk("win1024 m_ch", longint'(bus10.m_ch), 0);
    end
    bus10.m_ready = 1'b1;
    bus10.enable = 1'b0;
    @(negedge clk);
    bus10.m_ready = 1'b0;

    // Single channel, latency and turnaround.
    fill_const(0, 100); fill_const(1, -7); fill_const(2, 5000); fill_const(3, -32768);
    bus.ch_en = 4'b0001;
    bus.enable = 1'b1;
    do_reset();
    acc_n = 0; last_acc = -10; valid_at = -1;
    for (int n = 0; n < 30; n++) begin
      if (bus.m_valid) begin valid_at = n; break; end
      if (bus.s_ready[0] && bus.s_valid[0]) begin acc_n++; last_acc = n; end
      @(negedge clk);
    end
    if (valid_at < 0) timeout("lat");
    else begin
      chk("lat accepts", acc_n, 4);
      chk("lat distance", valid_at - last_acc, 1);
      chk("lat m_ch", longint'(bus.m_ch), 0);
      chk("lat m_ms", longint'(bus.m_ms), 10000);
      chk("lat busy", longint'(bus.busy), 1);
    end
    handshake();
    gap = 1;
    while (!bus.s_ready[0] && gap < 10) begin @(negedge clk); gap++; end
    chk("turnaround", gap, 2);

    // Table-driven round-robin sequence.
    bus.ch_en = tbl[0].ch_en;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      expect_result($sformatf("tbl%0d", i), tbl[i].exp_ch, tbl[i].exp_ms);
      if (i + 1 < 8) bus.ch_en = tbl[i+1].ch_en;
      handshake();
    end

    // Reset values after a nonzero result on channel 3.
    rst = 1'b1;
    @(negedge clk);
    chk("rst s_ready", longint'(bus.s_ready), 0);
    chk("rst m_valid", longint'(bus.m_valid), 0);
    chk("rst m_ch",    longint'(bus.m_ch), 0);
    chk("rst m_ms",    longint'(bus.m_ms), 0);
    chk("rst busy",    longint'(bus.busy), 0);

    // Held result under backpressure, alternating 3/-3.
    for (int k = 0; k < 256; k++) strm[0][k] = (k % 2 == 0) ? 16'sd3 : -16'sd3;
    bus.ch_en = 4'b0001;
    do_reset();
    wait_valid(100, ok);
    if (!ok) timeout("hold");
    else begin
      chk("hold m_ms", longint'(bus.m_ms), 9);
      chk("hold m_ch", longint'(bus.m_ch), 0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (!(bus.m_valid && bus.m_ms == 32'd9 && bus.m_ch == '0 && bus.s_ready == '0)) bad++;
        @(negedge clk);
      end
      chk("hold stable", bad, 0);
      handshake();
      chk("hold single", longint'(bus.m_valid), 0);
    end

    // Abort on enable drop: window on ch1 discarded and retried on ch1.
    fill_const(0, 100);
    for (int k = 0; k < 256; k++) strm[1][k] = (k < 3) ? 16'sd1000 : 16'sd20;
    bus.ch_en = 4'b0011;
    do_reset();
    expect_result("abort pre", 0, 10000);
    handshake();
    nacc = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_ready[1]) nacc++;
      if (nacc == 3) break;
      @(negedge clk);
    end
    bus.enable = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.m_valid) bad++;
    end
    chk("abort no result", bad, 0);
    bus.enable = 1'b1;
    expect_result("abort retry", 1, 400);
    handshake();

`ifdef MS_THRESH_EN
    fill_const(0, 100); fill_const(1, 99);
    bus.thresh = 32'd9999;
    bus.ch_en = 4'b0011;
    do_reset();
    expect_result("thr ch0", 0, 10000);
    chk("thr fault0", longint'(bus.m_fault), 1);
    handshake();
    expect_result("thr ch1", 1, 9801);
    chk("thr fault1", longint'(bus.m_fault), 0);
    handshake();
    chk("thr sticky", longint'(bus.fault_sticky), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("thr sticky rst", longint'(bus.fault_sticky), 0);
    bus.thresh = 32'hFFFF_FFFF;
`endif

    // Random streams, random gaps and backpressure against a transaction-level model.
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 256; k++) strm[c][k] = DW'($urandom);
    for (int c = 0; c < NCH; c++) mptr[c] = 0;
    vld_pct = 60;
    model_last = NCH - 1;
    mask = NCH'($urandom_range(15, 1));
    bus.ch_en = mask;
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int r = 0; r < 6; r++) begin
        int ec;
        ec = rr_next(model_last, mask);
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          longint s;
          s = longint'(strm[ec][(mptr[ec] + k) % 256]);
          sum += s * s;
        end
        mptr[ec] += 4;
        expect_result($sformatf("rnd p%0d r%0d", ph, r), ec, sum >> 2);
        model_last = ec;
        repeat ($urandom_range(3)) @(negedge clk);
        if (r == 5) begin
          mask = NCH'($urandom_range(15, 1));
          bus.ch_en = mask;
        end
        handshake();
      end
    end
    chk("s_ready grant legality", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
